mod_mul_il_radk: RTL and testbench
==================================

# mod_mul_il_radk

Parametrised interleaved modular multiplier computing y = a·b mod m, LSB-first, consuming RLOG bits of a per iteration. It succeeds the fixed radix-4 multiplier in the modular-arithmetic library. New relative to that design:
- generic radix 2^RLOG;
- a precomputed table of multiples of m, built in a LOAD phase;
- an explicit FSM with busy/ready handshake;
- deterministic fixed latency, with early exit as a compile-time option.

## Interface
- NBITS, 4096: operand/modulus width.
- RLOG, 2: bits of a consumed per iteration; legal 1..3.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_p  in  1  single-cycle start pulse; sampled only in IDLE.
- a  in  NBITS  multiplier; a < m required.
- b  in  NBITS  multiplicand; b < m required.
- m  in  NBITS  modulus.
- ready  out  1  high in IDLE and DONE; reset 1.
- busy  out  1  high in LOAD and ITER; reset 0.
- y  out  NBITS  result; valid from DONE until the next accepted start; reset 0.
- done_irq_p  out  1  one-cycle pulse in DONE; reset 0.

## Operation
FSM states and transitions:
- IDLE: on start_p, latch a, b and m; clear y; go to LOAD.
- LOAD: build mtab[k] = k·m for k = 0..2^RLOG, one entry per cycle (mtab[k] = mtab[k-1] + m). Duration is 2^RLOG cycles. Entries are NBITS+RLOG+1 bits wide.
- ITER: each cycle, with digit d = a_loc[RLOG-1:0]:
  - y ← red(y + d·b_cur).
  - b_cur ← red(b_cur·2^RLOG).
  - a_loc ← a_loc >> RLOG.
  - ITERS = ceil(NBITS/RLOG); a is zero-padded at the top.
- DONE: one cycle; done_irq_p = 1. Return to IDLE, or accept start_p directly into LOAD.

Arithmetic rules:
- red(v) subtracts the largest mtab[k] ≤ v. All compares run in parallel; the largest passing k wins.
- Bounds: y + d·b_cur < (2^RLOG + 1)·m, and b_cur·2^RLOG < 2^RLOG·m. One reduction step is therefore exact.
- Intermediate width is NBITS+RLOG+1; stored y and b_cur are NBITS.

Boundary conditions:
- m == 0: LOAD runs as normal; ITER is skipped; DONE presents y = 0.
- Operands ≥ m: result undefined, no hang. Latency is unchanged.
- start_p while busy: ignored, no state change.
- start_p in the same cycle as DONE: accepted. done_irq_p still pulses, and y is cleared at the next edge.
- Reset mid-operation: all state returns to reset values immediately. No done_irq_p is generated.

## Timing
- The accepting edge is edge 0.
- LOAD occupies cycles 1..2^RLOG.
- ITER occupies the next ITERS cycles.
- done_irq_p is high in cycle 2^RLOG + ITERS + 1.
- Example, NBITS=16, RLOG=2: done at cycle 13.
- busy falls in the same cycle done_irq_p rises.
- y updates only at ITER edges and holds afterwards.

## Configuration
- MOD_MUL_IL_EARLY_EXIT_EN defined:
  - ITER ends after the first cycle whose updated a_loc is zero.
  - Minimum of one ITER cycle.
  - Latency is 2^RLOG + (index of top nonzero digit + 1) + 1.
- Not defined: ITER always runs ITERS cycles (constant-time, side-channel safe).
- The result is identical in both modes.

## Structure
- Package mod_mul_il_pkg holds:
  - the state enum (IDLE, LOAD, ITER, DONE);
  - the function iters(NBITS, RLOG) = ceil division;
  - the localparam TAB = 2^RLOG + 1.
- Sub-module mod_red_kway(NBITS, RLOG): combinational select of the largest mtab[k] ≤ v and subtract. Instantiated twice, for the y path and the b_cur path.

## Test plan
- NBITS=16, RLOG=2; a=3, b=5, m=7 → y=1; done_irq_p at cycle 13; busy high in cycles 1..12.
- NBITS=16, RLOG=2; a=0xFFF0, b=0xFFF0, m=0xFFF1 → y=0x0001; b_cur reductions exercised every cycle.
- NBITS=16, RLOG=3; a=10, b=10, m=13 → y=9; then a=1, b=12, m=13 → y=12; latency 8+6+1=15 fixed.
- a=0 with MOD_MUL_IL_EARLY_EXIT_EN (NBITS=16, RLOG=2) → y=0, done at cycle 6; without the macro, done at 13.
- start_p pulsed at cycles 3 and 7 of a run → ignored, result unchanged; start_p in the DONE cycle → new run, done_irq_p pulse for the first run still seen.
- rst_n low at cycle 8 of a run → ready=1, busy=0, y=0, no done_irq_p; the next start gives the correct result.

Source files
------------

// File: rtl/mod_mul_il_pkg.sv
// Shared types and helpers for the interleaved radix-2^RLOG modular multiplier.
package mod_mul_il_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_e;

  localparam int RLOG_DEF = 2;
  localparam int TAB      = (1 << RLOG_DEF) + 1;

  function automatic int iters(input int nbits, input int rlog);
    return (nbits + rlog - 1) / rlog;
  endfunction

  function automatic int tab_size(input int rlog);
    return (1 << rlog) + 1;
  endfunction

endpackage

// File: rtl/mod_red_kway.sv
// One-step modular reduction: subtract the largest table entry k*m not exceeding v.
module mod_red_kway
  import mod_mul_il_pkg::*;
#(
  parameter int NBITS = 4096,
  parameter int RLOG  = 2
) (
  input  logic [NBITS+RLOG:0] v,
  input  logic [NBITS+RLOG:0] mtab [tab_size(RLOG)],
  output logic [NBITS-1:0]    r
);

  localparam int NTAB = tab_size(RLOG);

  logic [NBITS-1:0] sel;

  // Table is monotonic, so the last passing compare is the largest multiple.
  // The difference is below m, so only the low NBITS bits are needed.
  always_comb begin
    sel = '0;
    for (int k = 0; k < NTAB; k++) begin
      if (mtab[k] <= v) sel = mtab[k][NBITS-1:0];
    end
  end

  assign r = v[NBITS-1:0] - sel;

endmodule

// File: rtl/mod_mul_il_radk.sv
// Interleaved modular multiplier y = a*b mod m, RLOG bits of a per cycle.
// Optional early exit on zero remaining digits: define MOD_MUL_IL_EARLY_EXIT_EN.
module mod_mul_il_radk
  import mod_mul_il_pkg::*;
#(
  parameter int NBITS = 4096,
  parameter int RLOG  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_p,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [NBITS-1:0] m,
  output logic             ready,
  output logic             busy,
  output logic [NBITS-1:0] y,
  output logic             done_irq_p
);

  // states: IDLE wait | LOAD build k*m table | ITER one digit per cycle | DONE result + irq
  localparam int NLOAD = 1 << RLOG;
  localparam int NTAB  = tab_size(RLOG);
  localparam int W     = NBITS + RLOG + 1;
  localparam int ITERS = iters(NBITS, RLOG);
  localparam int AW    = ITERS * RLOG;
  localparam int CMAX  = (NLOAD > ITERS) ? NLOAD : ITERS;
  localparam int CW    = $clog2(CMAX + 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    a_q, a_d;
  logic [NBITS-1:0] b_q, b_d;
  logic [NBITS-1:0] m_q, m_d;
  logic [NBITS-1:0] y_q, y_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     tab_q [1:NTAB-1];
  logic [W-1:0]     mtab  [NTAB];
  logic             tab_clr, tab_shift;

  logic [RLOG-1:0]  digit;
  logic [AW-1:0]    a_shift;
  logic [W-1:0]     v_y, v_b;
  logic [NBITS-1:0] y_red, b_red;
  logic             last_iter;

  always_comb begin
    mtab[0] = '0;
    for (int k = 1; k < NTAB; k++) mtab[k] = tab_q[k];
  end

  assign digit   = a_q[RLOG-1:0];
  assign a_shift = a_q >> RLOG;
  assign v_y     = W'(y_q) + W'(b_q) * W'(digit);
  assign v_b     = {1'b0, b_q, {RLOG{1'b0}}};

  mod_red_kway #(.NBITS(NBITS), .RLOG(RLOG)) u_red_y (
    .v(v_y), .mtab(mtab), .r(y_red)
  );

  mod_red_kway #(.NBITS(NBITS), .RLOG(RLOG)) u_red_b (
    .v(v_b), .mtab(mtab), .r(b_red)
  );

`ifdef MOD_MUL_IL_EARLY_EXIT_EN
  assign last_iter = (cnt_q == CW'(1)) || (a_shift == '0);
`else
  assign last_iter = (cnt_q == CW'(1));
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    m_d       = m_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    tab_clr   = 1'b0;
    tab_shift = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_p) begin
          a_d     = AW'(a);
          b_d     = b;
          m_d     = m;
          y_d     = '0;
          cnt_d   = CW'(NLOAD);
          tab_clr = 1'b1;
          state_d = LOAD;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        tab_shift = 1'b1;
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          if (m_q == '0) begin
            state_d = DONE;
          end else begin
            state_d = ITER;
            cnt_d   = CW'(ITERS);
          end
        end
      end
      ITER: begin
        y_d   = y_red;
        b_d   = b_red;
        a_d   = a_shift;
        cnt_d = cnt_q - CW'(1);
        if (last_iter) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  // Entries shift down as they are built, so after NLOAD cycles tab_q[k] = k*m.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < NTAB; k++) tab_q[k] <= '0;
    end else if (tab_clr) begin
      tab_q[NTAB-1] <= '0;
    end else if (tab_shift) begin
      for (int k = 1; k < NTAB - 1; k++) tab_q[k] <= tab_q[k+1];
      tab_q[NTAB-1] <= tab_q[NTAB-1] + W'(m_q);
    end
  end

  assign ready      = (state_q == IDLE) || (state_q == DONE);
  assign busy       = (state_q == LOAD) || (state_q == ITER);
  assign done_irq_p = (state_q == DONE);
  assign y          = y_q;

endmodule

// File: tb/tb_mod_mul_il_radk.sv
// Self-checking bench for mod_mul_il_radk: NBITS=16 with RLOG=2 and RLOG=3 instances.
module tb_mod_mul_il_radk;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start2 = 1'b0, start3 = 1'b0;
  logic [15:0] a_in = '0, b_in = '0, m_in = '0;
  logic        ready2, busy2, done2, ready3, busy3, done3;
  logic [15:0] y2, y3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mod_mul_il_radk #(.NBITS(16), .RLOG(2)) u_r2 (
    .clk(clk), .rst_n(rst_n), .start_p(start2), .a(a_in), .b(b_in), .m(m_in),
    .ready(ready2), .busy(busy2), .y(y2), .done_irq_p(done2)
  );

  mod_mul_il_radk #(.NBITS(16), .RLOG(3)) u_r3 (
    .clk(clk), .rst_n(rst_n), .start_p(start3), .a(a_in), .b(b_in), .m(m_in),
    .ready(ready3), .busy(busy3), .y(y3), .done_irq_p(done3)
  );

  typedef struct {
    int          rlog;
    logic [15:0] a, b, m, y;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [15:0] a, b, m);
    longint p;
    if (m == 0) return 16'h0;
    p = longint'(a) * longint'(b);
    return 16'(p % longint'(m));
  endfunction

  // Cycle (after the accepting edge) in which done_irq_p is high.
  function automatic int ref_lat(input logic [15:0] a, m, input int rlog);
    int nload = 1 << rlog;
    int its   = (16 + rlog - 1) / rlog;
    int n     = 0;
    if (m == 0) return nload + 1;
`ifdef MOD_MUL_IL_EARLY_EXIT_EN
    for (int i = 0; i < its; i++)
      if (((a >> (i * rlog)) & ((1 << rlog) - 1)) != 0) n = i + 1;
    if (n == 0) n = 1;
    return nload + n + 1;
`else
    n = its;
    return nload + n + 1;
`endif
  endfunction

  function automatic logic done_of(input int rlog);
    return (rlog == 3) ? done3 : done2;
  endfunction
  function automatic logic busy_of(input int rlog);
    return (rlog == 3) ? busy3 : busy2;
  endfunction
  function automatic logic ready_of(input int rlog);
    return (rlog == 3) ? ready3 : ready2;
  endfunction
  function automatic logic [15:0] y_of(input int rlog);
    return (rlog == 3) ? y3 : y2;
  endfunction

  // Called at a negedge; returns at the negedge of cycle 1 of the new run.
  task automatic do_start(input int rlog, input logic [15:0] ia, ib, im);
    a_in = ia; b_in = ib; m_in = im;
    if (rlog == 3) start3 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; start3 = 1'b0;
  endtask

  // Returns at the negedge of the DONE cycle (or after the budget with lat=0).
  task automatic wait_done(input int rlog, input bit glitch,
                           output int lat, output logic [15:0] oy, output bit hs_ok);
    lat = 0; oy = '0; hs_ok = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      if (c > 1) @(negedge clk);
      start2 = 1'b0;
      if (done_of(rlog)) begin
        lat = c;
        oy  = y_of(rlog);
        if (busy_of(rlog) || !ready_of(rlog)) hs_ok = 1'b0;
        break;
      end
      if (!busy_of(rlog) || ready_of(rlog)) hs_ok = 1'b0;
      if (glitch && (c == 3 || c == 7)) begin
        start2 = 1'b1; a_in = 16'd9; b_in = 16'd9; m_in = 16'd11;
      end
    end
    start2 = 1'b0;
  endtask

  task automatic run(input string nm, input int rlog, input logic [15:0] ia, ib, im,
                     input logic [15:0] y_exp, input bit glitch);
    int          lat;
    logic [15:0] oy;
    bit          hs;
    do_start(rlog, ia, ib, im);
    wait_done(rlog, glitch, lat, oy, hs);
    chk({nm, " y"}, oy, y_exp);
    chk({nm, " latency"}, lat, ref_lat(ia, im, rlog));
    chk({nm, " handshake"}, hs, 1);
    @(negedge clk);
    chk({nm, " irq one cycle"}, {done_of(rlog), ready_of(rlog)}, 2'b01);
    chk({nm, " y holds"}, y_of(rlog), y_exp);
  endtask

  initial begin
    vec_t        tv[$];
    int          lat;
    int          npulse;
    logic [15:0] oy, ra, rb, rm;
    bit          hs;

    tv.push_back('{2, 16'd3,     16'd5,     16'd7,     16'd1});
    tv.push_back('{2, 16'hFFF0,  16'hFFF0,  16'hFFF1,  16'h0001});
    tv.push_back('{2, 16'd0,     16'h1234,  16'h8001,  16'd0});
    tv.push_back('{2, 16'd1,     16'h7FFF,  16'h8000,  16'h7FFF});
    tv.push_back('{2, 16'h8000,  16'd2,     16'hFFFF,  16'd1});
    tv.push_back('{2, 16'd5,     16'd6,     16'd0,     16'd0});
    tv.push_back('{3, 16'd10,    16'd10,    16'd13,    16'd9});
    tv.push_back('{3, 16'd1,     16'd12,    16'd13,    16'd12});
    tv.push_back('{3, 16'hFFF0,  16'hFFF0,  16'hFFF1,  16'h0001});

    repeat (2) @(negedge clk);
    chk("reset r2", {ready2, busy2, done2, y2}, {3'b100, 16'h0});
    chk("reset r3", {ready3, busy3, done3, y3}, {3'b100, 16'h0});
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tv[i]) run($sformatf("vec%0d", i), tv[i].rlog, tv[i].a, tv[i].b, tv[i].m,
                        tv[i].y, 1'b0);

    for (int i = 0; i < 16; i++) begin
      int rl = (i % 4 == 3) ? 3 : 2;
      rm = 16'($urandom_range(1, 65535));
      ra = 16'($urandom % rm);
      rb = 16'($urandom % rm);
      run($sformatf("rand%0d", i), rl, ra, rb, rm, ref_mul(ra, rb, rm), 1'b0);
    end

`ifndef MOD_MUL_IL_EARLY_EXIT_EN
    do_start(2, 16'd0, 16'd5, 16'd7);
    wait_done(2, 1'b0, lat, oy, hs);
    chk("const-time a=0 latency", lat, 13);
    @(negedge clk);
`else
    do_start(2, 16'd0, 16'd5, 16'd7);
    wait_done(2, 1'b0, lat, oy, hs);
    chk("early-exit a=0 latency", lat, 6);
    @(negedge clk);
`endif

    run("start while busy", 2, 16'hFFF0, 16'hFFF0, 16'hFFF1, 16'h0001, 1'b1);

    do_start(2, 16'd3, 16'd5, 16'd7);
    wait_done(2, 1'b0, lat, oy, hs);
    chk("chain first irq", lat, ref_lat(16'd3, 16'd7, 2));
    chk("chain first y", oy, 16'd1);
    do_start(2, 16'd10, 16'd10, 16'd13);
    chk("chain y cleared", {busy2, y2}, {1'b1, 16'h0});
    wait_done(2, 1'b0, lat, oy, hs);
    chk("chain second y", oy, 16'd9);
    chk("chain second latency", lat, ref_lat(16'd10, 16'd13, 2));
    @(negedge clk);

    do_start(2, 16'hFFFF, 16'hFFFF, 16'd7);
    wait_done(2, 1'b0, lat, oy, hs);
    chk("operands >= m latency", lat, ref_lat(16'hFFFF, 16'd7, 2));
    @(negedge clk);

    do_start(2, 16'hFFF0, 16'hFFF0, 16'hFFF1);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid-run reset", {ready2, busy2, done2, y2}, {3'b100, 16'h0});
    @(negedge clk);
    rst_n = 1'b1;
    npulse = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done2) npulse++;
    end
    chk("no irq after reset", npulse, 0);
    run("after reset", 2, 16'd3, 16'd5, 16'd7, 16'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
